// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared types and constants for the divide sequencer.
//   - operand width, default timeout and destination width
//   - RV32M divide-class op encoding and FSM state encoding
//   - INT_MIN / all-ones constants used by the corner-case resolver
//   - one-entry result cache payload (used when DIV_SEQ_CACHE_EN is defined)
//   - is_signed / is_rem op decode helpers
package div_seq_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned RD_W            = 5;
  localparam int unsigned OP_W            = 2;
  localparam int unsigned DIV_TIMEOUT_DEF = 80;

  localparam logic [OP_W-1:0] OP_DIV  = 2'b00;
  localparam logic [OP_W-1:0] OP_DIVU = 2'b01;
  localparam logic [OP_W-1:0] OP_REM  = 2'b10;
  localparam logic [OP_W-1:0] OP_REMU = 2'b11;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Last completed operation: operands, signedness class and both signed results.
  typedef struct packed {
    logic            valid;
    logic            sgn;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
  } cache_entry_t;

  // DIV and REM treat operands as two's complement.
  function automatic logic is_signed(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic is_rem(input logic [OP_W-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: dual-lane conditional two's-complement negate.
// Used both to take operand magnitudes and to restore result signs.
// Negating INT_MIN yields INT_MIN, which is the correct unsigned magnitude.
//   a, b             in   XLEN  values
//   neg_a, neg_b     in   1     negate the corresponding lane
//   a_fix_c, b_fix_c out  XLEN  combinational results
module div_sign_fix
  import div_seq_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            neg_a,
  input  logic            neg_b,
  output logic [XLEN-1:0] a_fix_c,
  output logic [XLEN-1:0] b_fix_c
);

  assign a_fix_c = neg_a ? ((~a) + XLEN'(1)) : a;
  assign b_fix_c = neg_b ? ((~b) + XLEN'(1)) : b;

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: controller between EX-stage issue of RV32M DIV/DIVU/REM/REMU
// and a multi-cycle unsigned divider core. Resolves divide-by-zero and signed
// overflow locally, otherwise starts the core, waits (bounded by DIV_TIMEOUT),
// fixes up signs and returns one write-back result. Holds the pipeline via
// stall and aborts cleanly on flush.
// Optional feature: define DIV_SEQ_CACHE_EN for a one-entry result cache that
// lets a DIV/REM pair on identical operands skip the core for the second op.
// Ports:
//   clk, reset                       clock, async active-high reset
//   issue_valid/op/rs1/rs2/rd        instruction from EX
//   flush                            kill in-flight operation
//   stall                            hold pipeline front end (combinational)
//   dv_start, dv_abort               one-cycle pulses to the core
//   dv_dividend, dv_divisor          unsigned magnitudes to the core
//   dv_done, dv_quotient/remainder   core result
//   wb_valid, wb_rd, wb_data, wb_err write-back result (wb_err = timeout)
module div_sequencer
  import div_seq_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [OP_W-1:0] issue_op,
  input  logic [XLEN-1:0] issue_rs1,
  input  logic [XLEN-1:0] issue_rs2,
  input  logic [RD_W-1:0] issue_rd,
  input  logic            flush,
  output logic            stall,
  output logic            dv_start,
  output logic            dv_abort,
  output logic [XLEN-1:0] dv_dividend,
  output logic [XLEN-1:0] dv_divisor,
  input  logic            dv_done,
  input  logic [XLEN-1:0] dv_quotient,
  input  logic [XLEN-1:0] dv_remainder,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err
);

  localparam int unsigned      CNT_W    = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  state_t          state;
  logic [OP_W-1:0] op_q;
  logic [RD_W-1:0] rd_q;
  logic            sa_q;
  logic            sb_q;
  logic [XLEN-1:0] q_raw;
  logic [XLEN-1:0] r_raw;
  logic [CNT_W-1:0] cnt;

  logic            issue_sgn_c;
  logic            issue_rem_c;
  logic            neg_rs1_c;
  logic            neg_rs2_c;
  logic            div0_c;
  logic            ovf_c;
  logic            hit_c;
  logic            accept_c;
  logic            timeout_c;
  logic            fix_done_c;
  logic [XLEN-1:0] mag_rs1_c;
  logic [XLEN-1:0] mag_rs2_c;
  logic [XLEN-1:0] q_fix_c;
  logic [XLEN-1:0] r_fix_c;
  logic [XLEN-1:0] corner_data_c;
  logic [XLEN-1:0] hit_data_c;
  logic [XLEN-1:0] fix_data_c;

  // Issue-side decode and RISC-V corner cases.
  assign issue_sgn_c = is_signed(issue_op);
  assign issue_rem_c = is_rem(issue_op);
  assign neg_rs1_c   = issue_sgn_c & issue_rs1[XLEN-1];
  assign neg_rs2_c   = issue_sgn_c & issue_rs2[XLEN-1];
  assign div0_c      = (issue_rs2 == '0);
  assign ovf_c       = issue_sgn_c && (issue_rs1 == INT_MIN) && (issue_rs2 == ALL_ONES);

  always_comb begin
    corner_data_c = '0;
    if (div0_c) begin
      corner_data_c = issue_rem_c ? issue_rs1 : ALL_ONES;
    end else begin
      corner_data_c = issue_rem_c ? '0 : INT_MIN;
    end
  end

  // Qualified events shared by the FSM and the cache.
  assign accept_c   = (state == IDLE) && issue_valid && !flush;
  assign timeout_c  = (state == BUSY) && !flush && !dv_done && (cnt == CNT_LAST);
  assign fix_done_c = (state == FIX) && !flush;

  // Operand magnitudes for the core.
  div_sign_fix u_operand_abs (
    .a       (issue_rs1),
    .b       (issue_rs2),
    .neg_a   (neg_rs1_c),
    .neg_b   (neg_rs2_c),
    .a_fix_c (mag_rs1_c),
    .b_fix_c (mag_rs2_c)
  );

  // Quotient takes the xor of the signs, remainder follows the dividend.
  div_sign_fix u_result_fix (
    .a       (q_raw),
    .b       (r_raw),
    .neg_a   (sa_q ^ sb_q),
    .neg_b   (sa_q),
    .a_fix_c (q_fix_c),
    .b_fix_c (r_fix_c)
  );

  assign fix_data_c = is_rem(op_q) ? r_fix_c : q_fix_c;

`ifdef DIV_SEQ_CACHE_EN
  cache_entry_t    cache;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;

  assign hit_c = cache.valid && (cache.sgn == issue_sgn_c) &&
                 (cache.rs1 == issue_rs1) && (cache.rs2 == issue_rs2);
  assign hit_data_c = issue_rem_c ? cache.r : cache.q;

  // Cache fill on completed fix-up; dropped on timeout, kept across flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      if (accept_c) begin
        rs1_q <= issue_rs1;
        rs2_q <= issue_rs2;
      end
      if (fix_done_c) begin
        cache <= '{valid: 1'b1, sgn: is_signed(op_q), rs1: rs1_q, rs2: rs2_q,
                   q: q_fix_c, r: r_fix_c};
      end else if (timeout_c) begin
        cache.valid <= 1'b0;
      end
    end
  end
`else
  assign hit_c      = 1'b0;
  assign hit_data_c = '0;
`endif

  // Hold the front end while an operation is being accepted or is in flight.
  assign stall = !reset && (((state == IDLE) && issue_valid) ||
                            (state == BUSY) || (state == FIX));

  // Main sequencer: state plus all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      q_raw       <= '0;
      r_raw       <= '0;
      cnt         <= '0;
      dv_start    <= 1'b0;
      dv_abort    <= 1'b0;
      dv_dividend <= '0;
      dv_divisor  <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_err      <= 1'b0;
    end else begin
      dv_start <= 1'b0;
      dv_abort <= 1'b0;
      wb_valid <= 1'b0;
      wb_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            op_q <= issue_op;
            rd_q <= issue_rd;
            if (div0_c || ovf_c) begin
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_rd    <= issue_rd;
              wb_data  <= corner_data_c;
            end else if (hit_c) begin
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_rd    <= issue_rd;
              wb_data  <= hit_data_c;
            end else begin
              state       <= BUSY;
              sa_q        <= neg_rs1_c;
              sb_q        <= neg_rs2_c;
              dv_dividend <= mag_rs1_c;
              dv_divisor  <= mag_rs2_c;
              dv_start    <= 1'b1;
              cnt         <= '0;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state    <= IDLE;
            dv_abort <= 1'b1;
          end else if (dv_done) begin
            state <= FIX;
            q_raw <= dv_quotient;
            r_raw <= dv_remainder;
          end else if (timeout_c) begin
            state    <= RESP;
            dv_abort <= 1'b1;
            wb_valid <= 1'b1;
            wb_err   <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            state    <= RESP;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= fix_data_c;
          end
        end
        RESP: begin
          // Instruction retires this cycle; a new issue waits for IDLE.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer.
// The bench plays the divider core, driving dv_done/quotient/remainder by hand.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_div_sequencer;
  import div_seq_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            issue_valid = 1'b0;
  logic [OP_W-1:0] issue_op = '0;
  logic [XLEN-1:0] issue_rs1 = '0;
  logic [XLEN-1:0] issue_rs2 = '0;
  logic [RD_W-1:0] issue_rd = '0;
  logic            flush = 1'b0;
  logic            stall;
  logic            dv_start;
  logic            dv_abort;
  logic [XLEN-1:0] dv_dividend;
  logic [XLEN-1:0] dv_divisor;
  logic            dv_done = 1'b0;
  logic [XLEN-1:0] dv_quotient = '0;
  logic [XLEN-1:0] dv_remainder = '0;
  logic            wb_valid;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_op     (issue_op),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_rd     (issue_rd),
    .flush        (flush),
    .stall        (stall),
    .dv_start     (dv_start),
    .dv_abort     (dv_abort),
    .dv_dividend  (dv_dividend),
    .dv_divisor   (dv_divisor),
    .dv_done      (dv_done),
    .dv_quotient  (dv_quotient),
    .dv_remainder (dv_remainder),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_err       (wb_err)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [RD_W-1:0] rd);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rs1   = a;
    issue_rs2   = b;
    issue_rd    = rd;
    #1;
  endtask

  // Clock the issue in, then withdraw it.
  task automatic step_clear();
    tick();
    issue_valid = 1'b0;
    #1;
  endtask

  // Core answers after lat further BUSY cycles; check FIX, RESP and return to IDLE.
  task automatic core_reply(input int lat, input logic [31:0] q, input logic [31:0] r,
                            input logic [31:0] exp, input logic [RD_W-1:0] rd,
                            input string tag);
    repeat (lat) tick();
    if (lat > 0) chk_b({tag, "_start_single"}, dv_start, 1'b0);
    chk_b({tag, "_busy_stall"}, stall, 1'b1);
    dv_done      = 1'b1;
    dv_quotient  = q;
    dv_remainder = r;
    tick();
    dv_done = 1'b0;
    #1;
    chk_b({tag, "_fix_wbv"}, wb_valid, 1'b0);
    chk_b({tag, "_fix_stall"}, stall, 1'b1);
    tick();
    chk_b({tag, "_wbv"}, wb_valid, 1'b1);
    chk_w({tag, "_data"}, wb_data, exp);
    chk_w({tag, "_rd"}, 32'(wb_rd), 32'(rd));
    chk_b({tag, "_err"}, wb_err, 1'b0);
    chk_b({tag, "_resp_stall"}, stall, 1'b0);
    tick();
    chk_b({tag, "_wbv_drop"}, wb_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;

    // Reset: stall forced low even with an issue present.
    issue_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_b("rst_stall", stall, 1'b0);
    chk_b("rst_wbv", wb_valid, 1'b0);
    chk_b("rst_start", dv_start, 1'b0);
    chk_w("rst_dividend", dv_dividend, 32'h0);
    issue_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk_b("idle_stall", stall, 1'b0);

    // DIV -7 / 2, core latency 5 cycles: q=-3.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5);
    chk_b("div1_issue_stall", stall, 1'b1);
    step_clear();
    chk_b("div1_start", dv_start, 1'b1);
    chk_w("div1_dividend", dv_dividend, 32'd7);
    chk_w("div1_divisor", dv_divisor, 32'd2);
    core_reply(4, 32'd3, 32'd1, 32'hFFFF_FFFD, 5'd5, "div1");

    // REMU 0x1234 / 0 resolved locally, then a DIVU by 0 held during RESP.
    issue(OP_REMU, 32'h0000_1234, 32'h0, 5'd9);
    chk_b("remu0_issue_stall", stall, 1'b1);
    tick();
    issue(OP_DIVU, 32'd5, 32'd0, 5'd12);
    chk_b("remu0_wbv", wb_valid, 1'b1);
    chk_w("remu0_data", wb_data, 32'h0000_1234);
    chk_w("remu0_rd", 32'(wb_rd), 32'd9);
    chk_b("remu0_nostart", dv_start, 1'b0);
    chk_b("remu0_resp_stall", stall, 1'b0);
    tick();
    #1;
    chk_b("b2b_ignored_in_resp", wb_valid, 1'b0);
    chk_b("b2b_idle_stall", stall, 1'b1);
    step_clear();
    chk_b("divu0_wbv", wb_valid, 1'b1);
    chk_w("divu0_data", wb_data, 32'hFFFF_FFFF);
    chk_w("divu0_rd", 32'(wb_rd), 32'd12);
    tick();
    chk_b("divu0_wbv_drop", wb_valid, 1'b0);

    // Signed overflow, both flavours; core never started.
    issue(OP_DIV, INT_MIN, 32'hFFFF_FFFF, 5'd1);
    step_clear();
    chk_b("ovf_div_wbv", wb_valid, 1'b1);
    chk_w("ovf_div_data", wb_data, 32'h8000_0000);
    chk_b("ovf_div_nostart", dv_start, 1'b0);
    tick();
    issue(OP_REM, INT_MIN, 32'hFFFF_FFFF, 5'd1);
    step_clear();
    chk_b("ovf_rem_wbv", wb_valid, 1'b1);
    chk_w("ovf_rem_data", wb_data, 32'h0);
    chk_b("ovf_rem_nostart", dv_start, 1'b0);
    tick();

    // DIV INT_MIN / 2: magnitude of INT_MIN stays 0x8000_0000.
    issue(OP_DIV, INT_MIN, 32'd2, 5'd2);
    step_clear();
    chk_b("imin_start", dv_start, 1'b1);
    chk_w("imin_dividend", dv_dividend, 32'h8000_0000);
    core_reply(1, 32'h4000_0000, 32'h0, 32'hC000_0000, 5'd2, "imin");

    // REMU with the overflow operands is an ordinary unsigned op.
    issue(OP_REMU, INT_MIN, 32'hFFFF_FFFF, 5'd3);
    step_clear();
    chk_b("remu_big_start", dv_start, 1'b1);
    chk_w("remu_big_divisor", dv_divisor, 32'hFFFF_FFFF);
    core_reply(0, 32'h0, 32'h8000_0000, 32'h8000_0000, 5'd3, "remu_big");

    // Flush mid-BUSY, then a late dv_done must be ignored.
    issue(OP_DIVU, 32'd50, 32'd5, 5'd3);
    step_clear();
    chk_b("flush_start", dv_start, 1'b1);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk_b("flush_abort", dv_abort, 1'b1);
    chk_b("flush_wbv", wb_valid, 1'b0);
    chk_b("flush_stall", stall, 1'b0);
    dv_done     = 1'b1;
    dv_quotient = 32'd10;
    tick();
    dv_done = 1'b0;
    chk_b("flush_abort_single", dv_abort, 1'b0);
    chk_b("late_done_wbv", wb_valid, 1'b0);
    tick();
    chk_b("late_done_wbv2", wb_valid, 1'b0);
    chk_b("late_done_stall", stall, 1'b0);

    // Flush in IDLE blocks acceptance.
    issue(OP_DIVU, 32'd50, 32'd5, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    #1;
    chk_b("idle_flush_nostart", dv_start, 1'b0);
    chk_b("idle_flush_stall", stall, 1'b0);
    chk_b("idle_flush_wbv", wb_valid, 1'b0);

    // REM -7 / 2 with the core answering in the start cycle: r=-1.
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6);
    step_clear();
    chk_w("rem1_dividend", dv_dividend, 32'd7);
    core_reply(0, 32'd3, 32'd1, 32'hFFFF_FFFF, 5'd6, "rem1");

    // DIV 100/7 then REM 100/7.
    issue(OP_DIV, 32'd100, 32'd7, 5'd10);
    step_clear();
    chk_b("c_div_start", dv_start, 1'b1);
    core_reply(0, 32'd14, 32'd2, 32'd14, 5'd10, "c_div");
    issue(OP_REM, 32'd100, 32'd7, 5'd11);
`ifdef DIV_SEQ_CACHE_EN
    step_clear();
    chk_b("c_rem_hit_wbv", wb_valid, 1'b1);
    chk_w("c_rem_hit_data", wb_data, 32'd2);
    chk_b("c_rem_hit_nostart", dv_start, 1'b0);
    tick();
    issue(OP_DIVU, 32'd100, 32'd7, 5'd13);
    step_clear();
    chk_b("c_divu_miss_start", dv_start, 1'b1);
    core_reply(0, 32'd14, 32'd2, 32'd14, 5'd13, "c_divu");
`else
    step_clear();
    chk_b("c_rem_start", dv_start, 1'b1);
    core_reply(0, 32'd14, 32'd2, 32'd2, 5'd11, "c_rem");
`endif

    // Core never answers: abort plus error write-back after DIV_TIMEOUT cycles.
    issue(OP_DIVU, 32'd9, 32'd3, 5'd4);
    step_clear();
    chk_b("to_start", dv_start, 1'b1);
    k = 0;
    while (dv_abort !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk_w("to_cycles", 32'(k), 32'd80);
    chk_b("to_wbv", wb_valid, 1'b1);
    chk_b("to_err", wb_err, 1'b1);
    chk_w("to_data", wb_data, 32'h0);
    chk_w("to_rd", 32'(wb_rd), 32'd4);
    tick();
    chk_b("to_wbv_drop", wb_valid, 1'b0);
    chk_b("to_err_drop", wb_err, 1'b0);
    chk_b("to_abort_drop", dv_abort, 1'b0);

    // Reset mid-operation clears everything; a following dv_done is ignored.
    issue(OP_DIVU, 32'd20, 32'd4, 5'd7);
    step_clear();
    chk_w("mid_dividend", dv_dividend, 32'd20);
    reset = 1'b1;
    #1;
    chk_b("mid_rst_start", dv_start, 1'b0);
    chk_w("mid_rst_dividend", dv_dividend, 32'h0);
    chk_b("mid_rst_stall", stall, 1'b0);
    tick();
    reset = 1'b0;
    dv_done     = 1'b1;
    dv_quotient = 32'd5;
    tick();
    dv_done = 1'b0;
    chk_b("mid_rst_wbv", wb_valid, 1'b0);
    tick();
    chk_b("mid_rst_wbv2", wb_valid, 1'b0);
    chk_b("mid_rst_idle_stall", stall, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
